// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then
// clocks out data, odd parity and stop on device edges and checks the ACK.
module ps2_transmitter #(
  parameter int CLK_INHIBIT_CYCLES  = 5000,
  parameter int RTS_HOLD_CYCLES     = 100,
  parameter int EDGE_TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       clk_edge,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int M1 =
    (CLK_INHIBIT_CYCLES > RTS_HOLD_CYCLES) ?
    CLK_INHIBIT_CYCLES : RTS_HOLD_CYCLES;
  localparam int MAXC =
    (M1 > EDGE_TIMEOUT_CYCLES) ? M1 : EDGE_TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    RELEASE_WAIT
  } state_t;

  state_t state;
  state_t next;

  logic [CW-1:0] cnt;
  logic [3:0]    bit_count;
  logic [8:0]    shift;
  logic          data_bit;

  logic watch;
  logic timeout;
  logic inh_done;
  logic rts_done;

  // One counter serves the host timing phases and the edge watchdog
  assign watch    = (state == SEND) || (state == ACK) ||
                    (state == RELEASE_WAIT);
  assign timeout  = watch && (cnt == CW'(EDGE_TIMEOUT_CYCLES));
  assign inh_done = (cnt == CW'(CLK_INHIBIT_CYCLES - 1));
  assign rts_done = (cnt == CW'(RTS_HOLD_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (tx_start) next = INHIBIT;
      INHIBIT: if (inh_done) next = RTS;
      RTS:     if (rts_done) next = SEND;
      SEND: begin
        if (timeout) next = IDLE;
        else if (clk_edge && bit_count == 4'd9) next = ACK;
      end
      ACK: begin
        if (timeout) next = IDLE;
        else if (clk_edge)
          next = ps2_data_in ? IDLE : RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (timeout || (ps2_clk_in && ps2_data_in))
          next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_comb begin
    ps2_clk_drive_low  = (state == INHIBIT) || (state == RTS);
    ps2_data_drive_low = (state == RTS) ||
                         ((state == SEND) && data_bit && !timeout);
    tx_busy  = (state != IDLE);
    tx_done  = (state == RELEASE_WAIT) && !timeout &&
               ps2_clk_in && ps2_data_in;
    tx_error = timeout ||
               ((state == ACK) && clk_edge && ps2_data_in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      bit_count <= '0;
      shift     <= '0;
      data_bit  <= 1'b0;
    end else begin
      if (next != state || state == IDLE || (watch && clk_edge))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state == IDLE && tx_start)
        shift <= {~^tx_data, tx_data};

      // data_bit starts at 1 so the start bit stays low until edge 1
      if (state == RTS && rts_done) begin
        bit_count <= '0;
        data_bit  <= 1'b1;
      end else if (state == SEND && clk_edge && !timeout) begin
        bit_count <= bit_count + 1'b1;
        if (bit_count <= 4'd8) data_bit <= ~shift[bit_count];
        else                   data_bit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: a device model clocks frames while a
// scoreboard matches every tx_done/tx_error pulse against expectations.
module tb_ps2_transmitter;

  localparam int INH = 8;
  localparam int RTSH = 2;
  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clk_edge = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low;
  assign ps2_data_in = dev_data & ~ps2_data_drive_low;

  ps2_transmitter #(
    .CLK_INHIBIT_CYCLES (INH),
    .RTS_HOLD_CYCLES    (RTSH),
    .EDGE_TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .tx_start          (tx_start),
    .tx_data           (tx_data),
    .clk_edge          (clk_edge),
    .ps2_clk_in        (ps2_clk_in),
    .ps2_data_in       (ps2_data_in),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low),
    .tx_busy           (tx_busy),
    .tx_done           (tx_done),
    .tx_error          (tx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         ok;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Response code: 2 = done, 1 = error, 3 = both at once
  always @(negedge clk) begin
    if (reset && (tx_done || tx_error)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", {tx_done, tx_error}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("resp_%02h", mon_e.data),
              {tx_done, tx_error}, mon_e.ok ? 2 : 1);
      end
    end
  end

  function automatic bit odd_parity(logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return (n % 2 == 0);
  endfunction

  // Frame on the wire after edge k: data LSB first, parity, stop.
  function automatic bit exp_drive(logic [7:0] d, int k);
    if (k <= 8) return !d[k-1];
    if (k == 9) return !odd_parity(d);
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ack, 1 no ack, 2 silent device, 3 tx_start mid-send,
  // 4 reset after edge 4
  task automatic run_tx(logic [7:0] d, int mode);
    int cnt;
    int n;
    bit ack;
    exp_t e;
    ack = (mode != 1);
    n = 0;
    while (tx_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_start", tx_busy, 0);
    step();
    tx_start = 1'b1;
    tx_data  = d;
    e.data = d;
    e.ok   = (mode == 0 || mode == 3 || mode == 4);
    exp_q.push_back(e);
    step();
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ps2_clk_drive_low) cnt++;
      else if (cnt > 0) break;
    end
    check($sformatf("clk_hold_%02h", d), cnt, INH + RTSH);
    check($sformatf("start_bit_%02h", d), ps2_data_drive_low, 1);
    if (mode == 2) begin
      n = 0;
      while (!tx_error && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", n, TMO);
      check("timeout_clk_rel", ps2_clk_drive_low, 0);
      check("timeout_data_rel", ps2_data_drive_low, 0);
      return;
    end
    for (int k = 1; k <= 11; k++) begin
      repeat (2) step();
      if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk  = 1'b0;
      clk_edge = 1'b1;
      if (mode == 3 && k == 5) begin
        tx_start = 1'b1;
        tx_data  = 8'h55;
      end
      step();
      clk_edge = 1'b0;
      tx_start = 1'b0;
      @(negedge clk);
      if (k <= 10)
        check($sformatf("bit%0d_%02h", k, d),
              ps2_data_drive_low, exp_drive(d, k));
      if (mode == 4 && k == 4) begin
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("reset_async_outputs",
              {ps2_clk_drive_low, ps2_data_drive_low,
               tx_busy, tx_done, tx_error}, 0);
        repeat (3) step();
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        reset    = 1'b1;
        return;
      end
      if (k == 11) begin
        check($sformatf("ack_data_rel_%02h", d), ps2_data_drive_low, 0);
        check($sformatf("busy_after_ack_%02h", d), tx_busy, ack ? 1 : 0);
        check($sformatf("clk_rel_%02h", d), ps2_clk_drive_low, 0);
      end
      step();
      dev_clk = 1'b1;
    end
    if (ack) begin
      repeat (2) step();
      dev_data = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("busy_after_done_%02h", d), tx_busy, 0);
    end
  endtask

  initial begin
    int n;
    logic [7:0] d;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {ps2_clk_drive_low, ps2_data_drive_low,
           tx_busy, tx_done, tx_error}, 0);
    reset = 1'b1;
    run_tx(8'hED, 0);
    run_tx(8'h00, 0);
    run_tx(8'hFF, 1);
    run_tx(8'h3C, 2);
    run_tx(8'hA7, 3);
    run_tx(8'hA5, 4);
    run_tx(8'hF4, 0);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      run_tx(d, int'($urandom_range(0, 1)));
    end
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
